// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: fixed six T-state machine cycle that issues every W-bus load/drive strobe.
// Optional single-step WAIT state is built in when SAP1_SINGLE_STEP_EN is defined.
module controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk_i,
    input  logic       rst_i,
`ifdef SAP1_SINGLE_STEP_EN
    input  logic       step_i,
`endif
    input  logic [3:0] opcode_i,
    output logic       pc_inc_o,
    output logic       pc_en_o,
    output logic       mar_ld_n_o,
    output logic       ram_en_n_o,
    output logic       ir_ld_n_o,
    output logic       ir_en_o,
    output logic       a_ld_n_o,
    output logic       a_en_o,
    output logic       alu_sub_o,
    output logic       alu_en_o,
    output logic       b_ld_n_o,
    output logic       out_ld_n_o,
    output logic       hlt_o,
    output logic [5:0] t_state_o
);

    typedef enum logic [2:0] {
        S_T1   = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_T6   = 3'd5,
        S_HALT = 3'd6,
        S_WAIT = 3'd7
    } state_t;

`ifdef SAP1_SINGLE_STEP_EN
    localparam state_t RESET_STATE = S_WAIT;
    localparam state_t AFTER_T6    = S_WAIT;
`else
    localparam state_t RESET_STATE = S_T1;
    localparam state_t AFTER_T6    = S_T1;
`endif

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = (opcode_i == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = AFTER_T6;
            S_HALT:  state_d = S_HALT;
`ifdef SAP1_SINGLE_STEP_EN
            S_WAIT:  state_d = step_i ? S_T1 : S_WAIT;
`endif
            default: state_d = S_T1;
        endcase
    end

    // Control word: fetch in T1-T3 ignores the opcode; execute decodes the live opcode.
    // rst_i gates everything so an asserted reset silences the bus before any edge.
    always_comb begin
        pc_inc_o   = 1'b0;
        pc_en_o    = 1'b0;
        mar_ld_n_o = 1'b1;
        ram_en_n_o = 1'b1;
        ir_ld_n_o  = 1'b1;
        ir_en_o    = 1'b0;
        a_ld_n_o   = 1'b1;
        a_en_o     = 1'b0;
        alu_sub_o  = 1'b0;
        alu_en_o   = 1'b0;
        b_ld_n_o   = 1'b1;
        out_ld_n_o = 1'b1;
        hlt_o      = 1'b0;
        t_state_o  = 6'b000000;
        if (rst_i) begin
            t_state_o = 6'b000001;
        end else begin
            case (state_q)
                S_T1: begin
                    t_state_o  = 6'b000001;
                    pc_en_o    = 1'b1;
                    mar_ld_n_o = 1'b0;
                end
                S_T2: begin
                    t_state_o = 6'b000010;
                    pc_inc_o  = 1'b1;
                end
                S_T3: begin
                    t_state_o  = 6'b000100;
                    ram_en_n_o = 1'b0;
                    ir_ld_n_o  = 1'b0;
                end
                S_T4: begin
                    t_state_o = 6'b001000;
                    case (opcode_i)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_en_o    = 1'b1;
                            mar_ld_n_o = 1'b0;
                        end
                        OP_OUT: begin
                            a_en_o     = 1'b1;
                            out_ld_n_o = 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    t_state_o = 6'b010000;
                    case (opcode_i)
                        OP_LDA: begin
                            ram_en_n_o = 1'b0;
                            a_ld_n_o   = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_en_n_o = 1'b0;
                            b_ld_n_o   = 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    t_state_o = 6'b100000;
                    if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                        alu_en_o  = 1'b1;
                        a_ld_n_o  = 1'b0;
                        alu_sub_o = (opcode_i == OP_SUB);
                    end
                end
                S_HALT: hlt_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Randomized self-checking bench for controller_sequencer against a table-driven T-state model.
module tb_controller_sequencer;

    logic       clk_i;
    logic       rst_i;
    logic [3:0] opcode_i;
`ifdef SAP1_SINGLE_STEP_EN
    logic       step_i;
`endif
    logic pc_inc_o, pc_en_o, mar_ld_n_o, ram_en_n_o, ir_ld_n_o, ir_en_o;
    logic a_ld_n_o, a_en_o, alu_sub_o, alu_en_o, b_ld_n_o, out_ld_n_o, hlt_o;
    logic [5:0] t_state_o;

    int total = 0;
    int bad   = 0;

    // Model: m_t = 1..6 for T1..T6, 0 = halted, 7 = waiting for a step.
    int m_t;
    bit m_rst;

`ifdef SAP1_SINGLE_STEP_EN
    localparam int RST_T = 7;
`else
    localparam int RST_T = 1;
`endif

    controller_sequencer dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
`ifdef SAP1_SINGLE_STEP_EN
        .step_i     (step_i),
`endif
        .opcode_i   (opcode_i),
        .pc_inc_o   (pc_inc_o),
        .pc_en_o    (pc_en_o),
        .mar_ld_n_o (mar_ld_n_o),
        .ram_en_n_o (ram_en_n_o),
        .ir_ld_n_o  (ir_ld_n_o),
        .ir_en_o    (ir_en_o),
        .a_ld_n_o   (a_ld_n_o),
        .a_en_o     (a_en_o),
        .alu_sub_o  (alu_sub_o),
        .alu_en_o   (alu_en_o),
        .b_ld_n_o   (b_ld_n_o),
        .out_ld_n_o (out_ld_n_o),
        .hlt_o      (hlt_o),
        .t_state_o  (t_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [18:0] dut_w;
    assign dut_w = {pc_inc_o, pc_en_o, mar_ld_n_o, ram_en_n_o, ir_ld_n_o, ir_en_o,
                    a_ld_n_o, a_en_o, alu_sub_o, alu_en_o, b_ld_n_o, out_ld_n_o,
                    hlt_o, t_state_o};

    function automatic logic [18:0] exp_word(input int t, input logic [3:0] op, input bit r);
        logic cp = 1'b0, ep = 1'b0, lm = 1'b1, ce = 1'b1, li = 1'b1, ei = 1'b0;
        logic la = 1'b1, ea = 1'b0, su = 1'b0, eu = 1'b0, lb = 1'b1, lo = 1'b1, h = 1'b0;
        logic [5:0] ts = 6'b0;
        if (r) begin
            ts = 6'b000001;
        end else if (t == 0) begin
            h = 1'b1;
        end else if (t >= 1 && t <= 6) begin
            ts = 6'(1 << (t - 1));
            if (t == 1) begin ep = 1'b1; lm = 1'b0; end
            else if (t == 2) cp = 1'b1;
            else if (t == 3) begin ce = 1'b0; li = 1'b0; end
            else if (op == 4'h0) begin
                if (t == 4) begin ei = 1'b1; lm = 1'b0; end
                if (t == 5) begin ce = 1'b0; la = 1'b0; end
            end else if (op == 4'h1 || op == 4'h2) begin
                if (t == 4) begin ei = 1'b1; lm = 1'b0; end
                if (t == 5) begin ce = 1'b0; lb = 1'b0; end
                if (t == 6) begin eu = 1'b1; la = 1'b0; su = (op == 4'h2); end
            end else if (op == 4'hE && t == 4) begin
                ea = 1'b1; lo = 1'b0;
            end
        end
        return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, h, ts};
    endfunction

    task automatic check_now(input string nm);
        logic [18:0] e;
        int drivers;
        e = exp_word(m_t, opcode_i, m_rst);
        total++;
        if (dut_w !== e) begin
            bad++;
            $display("FAIL %s t=%0d op=%h: got %b want %b", nm, m_t, opcode_i, dut_w, e);
        end
        drivers = int'(pc_en_o) + int'(!ram_en_n_o) + int'(ir_en_o) + int'(a_en_o) + int'(alu_en_o);
        total++;
        if (drivers > 1) begin
            bad++;
            $display("FAIL %s_bus_excl: got %0d drivers want <=1", nm, drivers);
        end
    endtask

    task automatic tick();
        if (m_t == 0) m_t = 0;
        else if (m_t == 4 && opcode_i == 4'hF) m_t = 0;
        else if (m_t == 6) m_t = RST_T;
`ifdef SAP1_SINGLE_STEP_EN
        else if (m_t == 7) m_t = step_i ? 1 : 7;
`endif
        else m_t = m_t + 1;
        @(posedge clk_i);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after one model-tracked edge.
    task automatic run_cycle(input string nm);
        #1;
        check_now(nm);
        tick();
    endtask

    task automatic do_reset(input string nm);
        rst_i = 1'b1;
        m_rst = 1'b1;
        #1;
        check_now({nm, "_in_reset"});
        @(negedge clk_i);
        rst_i = 1'b0;
        m_rst = 1'b0;
        m_t   = RST_T;
        #1;
        check_now({nm, "_release"});
        tick();
    endtask

    task automatic run_instr(input logic [3:0] op, input string nm);
        opcode_i = op;
        for (int i = 0; i < 7; i++) run_cycle(nm);
    endtask

    task automatic test_reset();
        @(posedge clk_i);
        #1;
        do_reset("reset");
    endtask

    task automatic test_lda();
        run_instr(4'h0, "lda");
    endtask

    task automatic test_add_sub();
        run_instr(4'h1, "add");
        run_instr(4'h2, "sub");
    endtask

    task automatic test_out_and_unknown();
        run_instr(4'hE, "out");
        run_instr(4'h7, "unknown");
    endtask

    task automatic test_hlt();
        int guard = 0;
        opcode_i = 4'hF;
        while (m_t != 0 && guard < 20) begin
            run_cycle("hlt_approach");
            guard++;
        end
        total++;
        if (hlt_o !== 1'b1) begin
            bad++;
            $display("FAIL hlt_entry: got hlt=%b want 1", hlt_o);
        end
        for (int i = 0; i < 20; i++) begin
            opcode_i = 4'($urandom_range(0, 15));
            run_cycle("hlt_hold");
        end
        do_reset("hlt_reset");
        opcode_i = 4'h0;
        run_cycle("hlt_after_reset");
    endtask

    task automatic test_async_reset();
        int guard = 0;
        opcode_i = 4'h1;
        while (m_t != 5 && guard < 20) begin
            run_cycle("add_to_t5");
            guard++;
        end
        total++;
        if (b_ld_n_o !== 1'b0) begin
            bad++;
            $display("FAIL add_t5_bld: got %b want 0", b_ld_n_o);
        end
        do_reset("mid_t5_reset");
        run_instr(4'h1, "add_after_abort");
    endtask

    task automatic test_random();
        int halted_for = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_t == 0) begin
                halted_for++;
                if (halted_for > 3) begin
                    halted_for = 0;
                    do_reset("rand_reset");
                    continue;
                end
            end
            case ($urandom_range(0, 7))
                0: opcode_i = 4'h0;
                1: opcode_i = 4'h1;
                2: opcode_i = 4'h2;
                3: opcode_i = 4'hE;
                4: opcode_i = ($urandom_range(0, 9) == 0) ? 4'hF : 4'h3;
                default: opcode_i = 4'($urandom_range(0, 14));
            endcase
            run_cycle("random");
        end
    endtask

`ifdef SAP1_SINGLE_STEP_EN
    task automatic test_single_step();
        step_i = 1'b0;
        do_reset("step_reset");
        for (int i = 0; i < 5; i++) run_cycle("wait_hold");
        step_i   = 1'b1;
        opcode_i = 4'h2;
        run_cycle("step_pulse");
        step_i = 1'b0;
        for (int i = 0; i < 6; i++) run_cycle("stepped_instr");
        for (int i = 0; i < 5; i++) run_cycle("wait_after_t6");
        total++;
        if (t_state_o !== 6'b0) begin
            bad++;
            $display("FAIL wait_tstate: got %b want 000000", t_state_o);
        end
        step_i = 1'b1;
    endtask
`endif

    initial begin
        rst_i    = 1'b1;
        m_rst    = 1'b1;
        m_t      = RST_T;
        opcode_i = 4'h0;
`ifdef SAP1_SINGLE_STEP_EN
        step_i   = 1'b1;
`endif
        test_reset();
        test_lda();
        test_add_sub();
        test_out_and_unknown();
        test_hlt();
        test_async_reset();
        test_random();
`ifdef SAP1_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- SAP-1 controller-sequencer. It is the initiator of every W-bus transfer: it issues the active-low load strobes that the general-purpose registers (A, B, IR, OUT) and the MAR sample, and the active-high bus-drive enables for the PC, RAM, IR, A and ALU.
- It runs a fixed 6-T-state machine cycle. It decodes the IR opcode nibble from T4 onward and stops permanently on HLT.

Parameters:
- OP_LDA, 4'h0, LDA opcode
- OP_ADD, 4'h1, ADD opcode
- OP_SUB, 4'h2, SUB opcode
- OP_OUT, 4'hE, OUT opcode
- OP_HLT, 4'hF, HLT opcode

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- opcode_i  in  4  IR upper nibble
- pc_inc_o  out  1  Cp, PC increment
- pc_en_o  out  1  Ep, PC drives bus
- mar_ld_n_o  out  1  Lm', MAR load, active low
- ram_en_n_o  out  1  CE', RAM drives bus, active low
- ir_ld_n_o  out  1  Li', IR load, active low
- ir_en_o  out  1  Ei, IR operand nibble drives bus
- a_ld_n_o  out  1  La', A load, active low
- a_en_o  out  1  Ea, A drives bus
- alu_sub_o  out  1  Su, 1 = subtract
- alu_en_o  out  1  Eu, ALU drives bus
- b_ld_n_o  out  1  Lb', B load, active low
- out_ld_n_o  out  1  Lo', OUT register load, active low
- hlt_o  out  1  halted flag
- t_state_o  out  6  one-hot T-state (bit0 = T1 … bit5 = T6); 0 when halted

Behaviour:
- Clocking and reset:
  - One clock, clk_i. Reset is asynchronous and active-high on rst_i.
  - State register is updated on the rising edge of clk_i.
  - Control outputs are combinational from the registered state and opcode_i, so each control word is held for the full T-state and sampled by the datapath at the closing edge.
- States: T1..T6 and HALT.
  - Transitions T1→T2→…→T6→T1, one per clock.
  - T4 with opcode_i==OP_HLT goes to HALT. HALT is absorbing until rst_i.
- Inactive control word: all _n outputs = 1; pc_inc, pc_en, ir_en, a_en, alu_sub, alu_en = 0.
- Reset:
  - While rst_i=1: state = T1, all controls inactive, hlt_o=0, t_state_o=6'b000001.
  - After release, T1 decode applies from the first cycle.
  - rst_i asserted in any state, including HALT or mid-instruction, aborts immediately. There is no partial completion.
- Fetch (all opcodes):
  - T1: pc_en=1, mar_ld_n=0.
  - T2: pc_inc=1.
  - T3: ram_en_n=0, ir_ld_n=0.
- Execute:
  - LDA: T4 ir_en=1, mar_ld_n=0; T5 ram_en_n=0, a_ld_n=0; T6 nop.
  - ADD: T4 as LDA; T5 ram_en_n=0, b_ld_n=0; T6 alu_en=1, a_ld_n=0, alu_sub=0.
  - SUB: as ADD, but T6 also has alu_sub=1.
  - OUT: T4 a_en=1, out_ld_n=0; T5, T6 nop.
  - HLT: T4 all controls inactive; next state HALT.
  - Any other opcode: T4–T6 nop; cycle continues normally.
- Decode timing:
  - opcode_i is ignored in T1–T3; fetch controls do not depend on it.
  - Opcode decode uses the live opcode_i in T4–T6.
- Bus exclusivity: at most one of pc_en, ram_en_n(low), ir_en, a_en, alu_en is active in any state.
- HALT: all controls inactive, hlt_o=1, t_state_o=0.

Optional Feature:
- Macro: SAP1_SINGLE_STEP_EN
- Defined:
  - Adds port step_i (in, 1) and a WAIT state, entered after T6 and on reset release instead of T1.
  - In WAIT: all controls inactive, t_state_o=0, hlt_o=0.
  - WAIT→T1 on the first rising edge with step_i=1; step_i is sampled only in WAIT.
  - HLT behaviour is unchanged.
- Undefined: no step_i port, no WAIT state; free-running as above.

Test Plan:
- Reset, then opcode_i=4'h0 (LDA) held → T1: pc_en=1, mar_ld_n=0; T2: pc_inc=1; T3: ram_en_n=0, ir_ld_n=0; T4: ir_en=1, mar_ld_n=0; T5: ram_en_n=0, a_ld_n=0; T6: inactive; 7th cycle back in T1.
- opcode_i=4'h1 then 4'h2 → T5 b_ld_n=0; T6 alu_en=1, a_ld_n=0 with alu_sub=0 (ADD) and alu_sub=1 (SUB).
- opcode_i=4'hE → T4 a_en=1, out_ld_n=0 only; T5 and T6 fully inactive.
- opcode_i=4'hF → T4 inactive; from next cycle hlt_o=1, t_state_o=0, held for 20 cycles; rst_i pulse returns to T1 with hlt_o=0.
- rst_i asserted asynchronously mid-T5 of ADD → controls go inactive immediately (b_ld_n=1 before the next edge); restart at T1. opcode_i=4'h7 → T4–T6 inactive, then T1.
- SAP1_SINGLE_STEP_EN defined → after reset and after each T6, WAIT holds with step_i=0 for 5 cycles; a single step_i=1 advances to T1 and runs exactly one 6-state instruction.
